filter_round_truncate: RTL and testbench



---
 rtl/filter_pkg.sv | 33 +++
 rtl/filter_sat_clamp.sv | 31 +++
 rtl/filter_round_truncate.sv | 70 +++++++
 tb/tb_filter_round_truncate.sv | 137 +++++++++++++
 4 files changed

// File: rtl/filter_pkg.sv
// ============================================================================
// filter_pkg : shared widths and output limits for the FIR output stage
// Rev 1.0
// ============================================================================
`default_nettype none

package filter_pkg;

  localparam int unsigned ACC_WIDTH  = 40;
  localparam int unsigned OUT_WIDTH  = 16;
  localparam int unsigned FRAC_SHIFT = 15;

  // One guard bit so the rounding add can never overflow.
  localparam int unsigned SUM_WIDTH  = ACC_WIDTH + 1;
  localparam int unsigned SHIFT_BITS = 5;

  localparam logic [OUT_WIDTH-1:0] OUT_MAX = 16'h7FFF;
  localparam logic [OUT_WIDTH-1:0] OUT_MIN = 16'h8000;

  typedef logic signed [SUM_WIDTH-1:0] sum_t;
  typedef logic        [OUT_WIDTH-1:0] sample_t;

  // True when every bit from the output sign bit upward agrees, i.e. the
  // value fits in a signed OUT_WIDTH sample.
  function automatic logic fits_out(input sum_t value);
    logic [SUM_WIDTH-OUT_WIDTH:0] upper;
    upper    = value[SUM_WIDTH-1:OUT_WIDTH-1];
    fits_out = (&upper) | ~(|upper);
  endfunction

endpackage : filter_pkg

`default_nettype wire

// File: rtl/filter_sat_clamp.sv
// ============================================================================
// filter_sat_clamp : range-checks the scaled value and saturates or wraps it
// Rev 1.0
// ============================================================================
`default_nettype none

module filter_sat_clamp
  import filter_pkg::*;
(
  input  logic [SUM_WIDTH-1:0] shifted,
  input  logic                 sat_en,
  output logic [OUT_WIDTH-1:0] sample,
  output logic                 ovf
);

  logic is_negative;

  assign is_negative = shifted[SUM_WIDTH-1];

  always_comb begin
    ovf    = ~fits_out(sum_t'(shifted));
    sample = shifted[OUT_WIDTH-1:0];
    // Wrap mode keeps the low bits even when out of range.
    if (ovf && sat_en) begin
      sample = is_negative ? OUT_MIN : OUT_MAX;
    end
  end

endmodule : filter_sat_clamp

`default_nettype wire

// File: rtl/filter_round_truncate.sv
// ============================================================================
// filter_round_truncate : round-half-up scaling of the MAC accumulator to a
// registered 16-bit sample with saturate/wrap and sticky overflow flag
// Rev 1.0
// ============================================================================
`default_nettype none

module filter_round_truncate
  import filter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ACC_WIDTH-1:0] acc_in,
  input  logic                 rf_sat,
  input  logic [2:0]           rf_shift,
  input  logic                 trig_filter_ovf_flag_clear,
  output logic [OUT_WIDTH-1:0] filter_out,
  output logic                 ro_filter_ovf_flag
);

  logic [SHIFT_BITS-1:0] total_shift;
  sum_t                  acc_ext;
  sum_t                  round_bias;
  sum_t                  rounded;
  sum_t                  shifted;
  logic [OUT_WIDTH-1:0]  sample_next;
  logic                  ovf;
  logic                  flag_next;

  assign total_shift = SHIFT_BITS'(FRAC_SHIFT) + SHIFT_BITS'(rf_shift);

  // Adding half an output LSB before the arithmetic shift gives ties
  // toward +infinity.
  always_comb begin
    acc_ext    = sum_t'({acc_in[ACC_WIDTH-1], acc_in});
    round_bias = sum_t'(1) <<< (total_shift - SHIFT_BITS'(1));
    rounded    = acc_ext + round_bias;
    shifted    = rounded >>> total_shift;
  end

  filter_sat_clamp u_sat_clamp (
    .shifted (shifted),
    .sat_en  (rf_sat),
    .sample  (sample_next),
    .ovf     (ovf)
  );

  // Set has priority over clear so an overflow is never lost.
  always_comb begin
    flag_next = ro_filter_ovf_flag;
    if (ovf) begin
      flag_next = 1'b1;
    end else if (trig_filter_ovf_flag_clear) begin
      flag_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      filter_out         <= '0;
      ro_filter_ovf_flag <= 1'b0;
    end else begin
      filter_out         <= sample_next;
      ro_filter_ovf_flag <= flag_next;
    end
  end

endmodule : filter_round_truncate

`default_nettype wire

// File: tb/tb_filter_round_truncate.sv
// ============================================================================
// tb_filter_round_truncate : directed + random scoreboard bench
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_filter_round_truncate;

  logic        clk;
  logic        rst_n;
  logic [39:0] acc_in;
  logic        rf_sat;
  logic [2:0]  rf_shift;
  logic        trig_filter_ovf_flag_clear;
  logic [15:0] filter_out;
  logic        ro_filter_ovf_flag;

  int errors = 0;
  int checks = 0;

  logic        model_flag = 1'b0;
  logic [16:0] exp_q[$];
  string       tag_q[$];

  filter_round_truncate dut (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .acc_in                     (acc_in),
    .rf_sat                     (rf_sat),
    .rf_shift                   (rf_shift),
    .trig_filter_ovf_flag_clear (trig_filter_ovf_flag_clear),
    .filter_out                 (filter_out),
    .ro_filter_ovf_flag         (ro_filter_ovf_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of stimulus, push the model prediction, then pop and
  // compare it against the registered outputs after the edge.
  task automatic step(input logic [39:0] a, input logic sat, input logic [2:0] sh,
                      input logic clr, input logic rn, input string tag);
    longint      av;
    longint      r;
    int          s;
    logic        ov;
    logic [15:0] eo;
    logic [16:0] got;
    string       t;
    @(negedge clk);
    acc_in = a; rf_sat = sat; rf_shift = sh;
    trig_filter_ovf_flag_clear = clr; rst_n = rn;
    if (!rn) begin
      eo = 16'h0000;
      model_flag = 1'b0;
    end else begin
      s  = 15 + int'(sh);
      av = longint'($signed(a));
      r  = (av + (longint'(1) << (s - 1))) >>> s;
      ov = (r > 32767) || (r < -32768);
      if (ov && sat) eo = (r < 0) ? 16'h8000 : 16'h7FFF;
      else           eo = r[15:0];
      if (ov)       model_flag = 1'b1;
      else if (clr) model_flag = 1'b0;
    end
    exp_q.push_back({model_flag, eo});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
    end else begin
      got = exp_q.pop_front();
      t   = tag_q.pop_front();
      chk({t, "_out"},  filter_out, got[15:0]);
      chk({t, "_flag"}, {15'd0, ro_filter_ovf_flag}, {15'd0, got[16]});
    end
  endtask

  initial begin
    rst_n = 1'b0; acc_in = '0; rf_sat = 1'b1; rf_shift = 3'd0;
    trig_filter_ovf_flag_clear = 1'b0;

    // Reset and small values
    step(40'h00_4000_0000, 1'b1, 3'd0, 1'b0, 1'b0, "reset");
    step(40'h00_0000_0001, 1'b1, 3'd0, 1'b0, 1'b1, "small_1");
    step(40'h00_0000_4000, 1'b1, 3'd0, 1'b0, 1'b1, "half_up");
    step(40'h00_0000_3FFF, 1'b1, 3'd0, 1'b0, 1'b1, "below_half");
    // Negative ties round toward +inf
    step(40'hFF_FFFF_C000, 1'b1, 3'd0, 1'b0, 1'b1, "neg_tie");
    step(40'hFF_FFFF_BFFF, 1'b1, 3'd0, 1'b0, 1'b1, "neg_below_tie");
    step(40'hFF_FFFF_8000, 1'b1, 3'd0, 1'b0, 1'b1, "neg_one_tie");
    // Shift sweep
    step(40'h00_4000_0000, 1'b1, 3'd0, 1'b0, 1'b1, "sweep_sh0_sat");
    step(40'h00_4000_0000, 1'b1, 3'd1, 1'b0, 1'b1, "sweep_sh1");
    step(40'h00_4000_0000, 1'b1, 3'd7, 1'b0, 1'b1, "sweep_sh7");
    // Wrap vs saturate
    step(40'h00_4000_0000, 1'b0, 3'd0, 1'b0, 1'b1, "wrap_pos");
    step(40'h80_0000_0000, 1'b1, 3'd0, 1'b0, 1'b1, "sat_neg_min");
    step(40'h80_0000_0000, 1'b0, 3'd0, 1'b0, 1'b1, "wrap_neg_min");
    // Flag clear, then set-beats-clear
    step(40'h00_0000_1234, 1'b1, 3'd0, 1'b1, 1'b1, "clear_flag");
    step(40'h00_0000_1234, 1'b1, 3'd0, 1'b0, 1'b1, "flag_stays_clear");
    step(40'h7F_0000_0000, 1'b1, 3'd2, 1'b1, 1'b1, "set_beats_clear");
    step(40'hFF_FFFF_FFFF, 1'b1, 3'd0, 1'b0, 1'b1, "flag_held");

    // Random stream with changing inputs each cycle
    for (int i = 0; i < 40; i++) begin
      logic [39:0] a;
      a = {8'($urandom), 32'($urandom)};
      if (i % 3 == 0) a = {{16{a[23]}}, a[23:0]};
      step(a, 1'($urandom), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 3) == 0), 1'b1, "random");
    end

    // Reset mid-stream overrides a coincident overflow
    step(40'h40_0000_0000, 1'b1, 3'd0, 1'b0, 1'b1, "pre_reset_ovf");
    step(40'h40_0000_0000, 1'b1, 3'd0, 1'b1, 1'b0, "mid_reset");
    step(40'h00_0000_8000, 1'b1, 3'd0, 1'b0, 1'b1, "post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_filter_round_truncate

`default_nettype wire
